// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-master RAM port-A arbiter.
package mem_arb_pkg;

  localparam int MASTER_FETCH = 0;
  localparam int MASTER_LSU   = 1;
  localparam int NUM_MASTERS  = 2;

  localparam int ARB_WIDTHAD  = 16;
  localparam int ARB_WIDTH    = 32;

  typedef struct packed {
    logic                   valid;
    logic                   we;
    logic [ARB_WIDTHAD-1:0] addr;
    logic [ARB_WIDTH-1:0]   wdata;
  } mem_req_t;

  // With two masters the round-robin successor is simply the other index.
  function automatic logic other_master(input logic m);
    return ~m;
  endfunction

endpackage

// File: rtl/mem_arb_resp_buf.sv
// Per-master read tracking: pending flag for the RAM latency cycle plus a
// one-entry response register drained by a valid/ready handshake.
module mem_arb_resp_buf
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_grant,
  input  logic             resp_ready,
  input  logic [WIDTH-1:0] ram_q,
  output logic             pending,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
    end else begin
      pending <= rd_grant;
      // A landing read overrides a same-cycle handshake.
      if (pending) begin
        resp_valid <= 1'b1;
        resp_data  <= ram_q;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter for RAM port A shared by fetch (m0) and load/store (m1).
// Optional performance counters are enabled by defining MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTHAD = 16,
  parameter int WIDTH   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m0_req_valid,
  output logic               m0_req_ready,
  input  logic [WIDTHAD-1:0] m0_req_addr,
  input  logic               m0_req_we,
  input  logic [WIDTH-1:0]   m0_req_wdata,
  output logic               m0_resp_valid,
  output logic [WIDTH-1:0]   m0_resp_data,
  input  logic               m0_resp_ready,
  input  logic               m1_req_valid,
  output logic               m1_req_ready,
  input  logic [WIDTHAD-1:0] m1_req_addr,
  input  logic               m1_req_we,
  input  logic [WIDTH-1:0]   m1_req_wdata,
  output logic               m1_resp_valid,
  output logic [WIDTH-1:0]   m1_resp_data,
  input  logic               m1_resp_ready,
  output logic [WIDTHAD-1:0] ram_address,
  output logic               ram_wren,
  output logic [WIDTH-1:0]   ram_data,
  output logic               ram_rden,
  input  logic [WIDTH-1:0]   ram_q
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_grants0,
  output logic [31:0]        perf_grants1,
  output logic [31:0]        perf_conflicts
`endif
);

  logic [NUM_MASTERS-1:0] req_valid, req_we, resp_ready;
  logic [NUM_MASTERS-1:0] pending, resp_valid, eligible, grant, rd_grant;
  logic [WIDTHAD-1:0]     req_addr  [NUM_MASTERS];
  logic [WIDTH-1:0]       req_wdata [NUM_MASTERS];
  logic [WIDTH-1:0]       resp_data [NUM_MASTERS];
  logic                   rr;
  logic                   grant_idx;

  assign req_valid  = {m1_req_valid, m0_req_valid};
  assign req_we     = {m1_req_we, m0_req_we};
  assign resp_ready = {m1_resp_ready, m0_resp_ready};
  assign req_addr[MASTER_FETCH]  = m0_req_addr;
  assign req_addr[MASTER_LSU]    = m1_req_addr;
  assign req_wdata[MASTER_FETCH] = m0_req_wdata;
  assign req_wdata[MASTER_LSU]   = m1_req_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      // Reads also need room for the response; writes never produce one.
      assign eligible[gi] = req_valid[gi] & ~pending[gi] &
                            (req_we[gi] | ~resp_valid[gi] | resp_ready[gi]);
      assign rd_grant[gi] = grant[gi] & ~req_we[gi];

      mem_arb_resp_buf #(.WIDTH(WIDTH)) u_resp_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_grant   (rd_grant[gi]),
        .resp_ready (resp_ready[gi]),
        .ram_q      (ram_q),
        .pending    (pending[gi]),
        .resp_valid (resp_valid[gi]),
        .resp_data  (resp_data[gi])
      );
    end
  endgenerate

  always_comb begin
    grant = eligible;
    if (&eligible) begin
      grant     = '0;
      grant[rr] = 1'b1;
    end
  end

  assign grant_idx = grant[MASTER_LSU];

  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    ram_rden    = 1'b0;
    if (|grant) begin
      ram_address = req_addr[grant_idx];
      ram_data    = req_wdata[grant_idx];
      ram_wren    = req_we[grant_idx];
      ram_rden    = ~req_we[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b0;
    end else if (|grant) begin
      rr <= other_master(grant_idx);
    end
  end

  assign m0_req_ready  = grant[MASTER_FETCH];
  assign m1_req_ready  = grant[MASTER_LSU];
  assign m0_resp_valid = resp_valid[MASTER_FETCH];
  assign m1_resp_valid = resp_valid[MASTER_LSU];
  assign m0_resp_data  = resp_data[MASTER_FETCH];
  assign m1_resp_data  = resp_data[MASTER_LSU];

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants0   <= '0;
      perf_grants1   <= '0;
      perf_conflicts <= '0;
    end else begin
      if (grant[MASTER_FETCH] && perf_grants0 != '1) perf_grants0 <= perf_grants0 + 32'd1;
      if (grant[MASTER_LSU] && perf_grants1 != '1) perf_grants1 <= perf_grants1 + 32'd1;
      if ((&eligible) && perf_conflicts != '1) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end
`endif

endmodule
